// File: rtl/mmio_csr_fabric.sv
// MMIO-to-CSR fabric: decodes Avalon MMIO into a global window and per-engine
// CSR windows, with a fixed-latency read pipeline, enable mask and cycle counters.
module mmio_csr_fabric #(
    parameter  int NUM_ENGINES     = 4,
    parameter  int NUM_CSRS        = 8,
    parameter  int MMIO_ADDR_WIDTH = 16,
    parameter  int RD_LATENCY      = 2,
    localparam int CSR_BITS        = $clog2(NUM_CSRS),
    localparam int WIN_BITS        = $clog2(NUM_ENGINES + 1)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [MMIO_ADDR_WIDTH-1:0]          avs_address,
    input  logic                                avs_read,
    input  logic                                avs_write,
    input  logic [63:0]                         avs_writedata,
    output logic                                avs_waitrequest,
    output logic [63:0]                         avs_readdata,
    output logic                                avs_readdatavalid,
    output logic [1:0]                          avs_response,
    input  logic [NUM_CSRS*64-1:0]              glob_rd_data,
    input  logic [NUM_ENGINES*NUM_CSRS*64-1:0]  eng_rd_data,
    input  logic [NUM_ENGINES-1:0]              eng_active,
    output logic                                glob_wr_valid,
    output logic [NUM_ENGINES-1:0]              eng_wr_valid,
    output logic [CSR_BITS-1:0]                 wr_idx,
    output logic [63:0]                         wr_data,
    output logic [NUM_ENGINES-1:0]              eng_enable
);

    localparam logic [CSR_BITS-1:0] IDX_ENABLE = CSR_BITS'(NUM_CSRS - 2);
    localparam logic [CSR_BITS-1:0] IDX_LAST   = CSR_BITS'(NUM_CSRS - 1);
    localparam logic [WIN_BITS-1:0] LAST_WIN   = WIN_BITS'(NUM_ENGINES);

    logic                               init_q;
    logic [NUM_ENGINES-1:0]             en_q, en_d;
    logic [NUM_ENGINES-1:0][47:0]       cyc_q, cyc_d;
    logic [15:0]                        bad_q, bad_d;
    logic                               gwv_q, gwv_d;
    logic [NUM_ENGINES-1:0]             ewv_q, ewv_d;
    logic [CSR_BITS-1:0]                widx_q, widx_d;
    logic [63:0]                        wdata_q, wdata_d;
    logic [RD_LATENCY-1:0]              vld_q;
    logic [RD_LATENCY-1:0]              err_q;
    logic [RD_LATENCY-1:0][63:0]        dat_q;

    logic [CSR_BITS-1:0] idx;
    logic [WIN_BITS-1:0] win;
    logic                mapped, rd_acc, wr_acc, rd_err;
    logic [63:0]         rd_val;

    assign idx    = avs_address[CSR_BITS-1:0];
    assign win    = avs_address[CSR_BITS +: WIN_BITS];
    assign mapped = ((avs_address >> (CSR_BITS + WIN_BITS)) == '0) && (win <= LAST_WIN);

    // A simultaneous read+write stalls only the read; the write goes through now.
    assign avs_waitrequest = init_q | ~reset_n | (avs_read & avs_write);
    assign rd_acc          = avs_read & ~avs_waitrequest;
    assign wr_acc          = avs_write & ~init_q & reset_n;

    always_comb begin
        rd_val = '0;
        rd_err = ~mapped;
        if (mapped) begin
            if (win == '0) begin
                if (idx == IDX_LAST)
                    rd_val = {32'd0, bad_q, 16'd0} | 64'(eng_active);
                else if (idx == IDX_ENABLE)
                    rd_val = 64'(en_q);
                else
                    rd_val = glob_rd_data[64*int'(idx) +: 64];
            end else begin
                for (int e = 0; e < NUM_ENGINES; e++) begin
                    if (win == WIN_BITS'(e + 1))
                        rd_val = (idx == IDX_LAST) ? 64'(cyc_q[e])
                                 : eng_rd_data[64*(e*NUM_CSRS + int'(idx)) +: 64];
                end
            end
        end
    end

    always_comb begin
        en_d    = en_q;
        bad_d   = bad_q;
        gwv_d   = 1'b0;
        ewv_d   = '0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        if ((rd_acc | wr_acc) && !mapped && bad_q != 16'hFFFF)
            bad_d = bad_q + 16'd1;
        for (int e = 0; e < NUM_ENGINES; e++)
            cyc_d[e] = (eng_active[e] && en_q[e] && cyc_q[e] != '1) ? cyc_q[e] + 48'd1 : cyc_q[e];
        // Clearing write overrides the increment computed above.
        if (wr_acc && mapped) begin
            widx_d  = idx;
            wdata_d = avs_writedata;
            if (win == '0) begin
                gwv_d = 1'b1;
                if (idx == IDX_ENABLE)
                    en_d = avs_writedata[NUM_ENGINES-1:0];
            end else begin
                for (int e = 0; e < NUM_ENGINES; e++) begin
                    if (win == WIN_BITS'(e + 1)) begin
                        ewv_d[e] = 1'b1;
                        if (idx == IDX_LAST)
                            cyc_d[e] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            init_q  <= 1'b1;
            en_q    <= '0;
            cyc_q   <= '0;
            bad_q   <= '0;
            gwv_q   <= 1'b0;
            ewv_q   <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            dat_q   <= '0;
        end else begin
            init_q  <= 1'b0;
            en_q    <= en_d;
            cyc_q   <= cyc_d;
            bad_q   <= bad_d;
            gwv_q   <= gwv_d;
            ewv_q   <= ewv_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            // Each stage loads only behind a valid, so the output stage holds its last response.
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_val;
                err_q[0] <= rd_err;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    dat_q[s] <= dat_q[s-1];
                    err_q[s] <= err_q[s-1];
                end
            end
        end
    end

    assign avs_readdatavalid = vld_q[RD_LATENCY-1];
    assign avs_readdata      = dat_q[RD_LATENCY-1];
    assign avs_response      = err_q[RD_LATENCY-1] ? 2'b11 : 2'b00;
    assign glob_wr_valid     = gwv_q;
    assign eng_wr_valid      = ewv_q;
    assign wr_idx            = widx_q;
    assign wr_data           = wdata_q;
    assign eng_enable        = en_q;

endmodule

// File: tb/tb_mmio_csr_fabric.sv
// Directed + randomized bench for mmio_csr_fabric against a cycle-level
// behavioural model built from address arithmetic and a response queue.
module tb_mmio_csr_fabric;
    localparam int NE = 4, NC = 8, AW = 16, RDL = 3, WINS = 8;
    localparam longint unsigned CYC_MAX = 64'h0000_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n, rd, wr;
    logic [AW-1:0]         addr;
    logic [63:0]           wdata;
    logic                  waitreq, rvalid, gwv;
    logic [63:0]           rdata, wr_data;
    logic [1:0]            resp;
    logic [NC*64-1:0]      glob;
    logic [NE*NC*64-1:0]   eng;
    logic [NE-1:0]         active, ewv, en;
    logic [2:0]            wr_idx;

    mmio_csr_fabric #(.NUM_ENGINES(NE), .NUM_CSRS(NC), .MMIO_ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(addr), .avs_read(rd), .avs_write(wr),
        .avs_writedata(wdata), .avs_waitrequest(waitreq), .avs_readdata(rdata),
        .avs_readdatavalid(rvalid), .avs_response(resp), .glob_rd_data(glob), .eng_rd_data(eng),
        .eng_active(active), .glob_wr_valid(gwv), .eng_wr_valid(ewv), .wr_idx(wr_idx),
        .wr_data(wr_data), .eng_enable(en));

    typedef struct { int due; logic [63:0] d; logic err; } rsp_t;
    rsp_t q[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit [NE-1:0]     m_en;
    longint unsigned m_cyc[NE];
    int              m_bad;
    bit              m_init = 1'b1;
    bit              m_gwv;
    bit [NE-1:0]     m_ewv;
    int              m_widx;
    logic [63:0]     m_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {decode_error, data} for a read of word address a in the current state.
    function automatic logic [64:0] ref_read(input int a);
        int idx, w, up;
        idx = a % NC;
        w   = (a / NC) % WINS;
        up  = a / (NC * WINS);
        if (up != 0 || w > NE) return {1'b1, 64'd0};
        if (w == 0) begin
            if (idx == NC - 1) return {1'b0, (64'(m_bad) << 16) | 64'(active)};
            if (idx == NC - 2) return {1'b0, 64'(m_en)};
            return {1'b0, glob[64*idx +: 64]};
        end
        if (idx == NC - 1) return {1'b0, 64'(m_cyc[w-1])};
        return {1'b0, eng[64*((w-1)*NC + idx) +: 64]};
    endfunction

    task automatic cycle();
        logic exp_wait;
        bit racc, wacc, mapped;
        int a, idx, w;
        logic [64:0] r;
        bit [NE-1:0] clr;
        #1;
        exp_wait = !reset_n || m_init || (rd && wr);
        chk("waitrequest", 64'(waitreq), 64'(exp_wait));
        if (!reset_n) begin
            m_init = 1'b1; m_en = '0; m_bad = 0; m_gwv = 0; m_ewv = '0;
            m_widx = 0; m_wdata = '0;
            foreach (m_cyc[e]) m_cyc[e] = 0;
            q.delete();
        end else begin
            racc = rd && !exp_wait;
            wacc = wr && !m_init;
            a = int'(addr);
            idx = a % NC;
            w = (a / NC) % WINS;
            mapped = (a / (NC * WINS) == 0) && (w <= NE);
            if (racc) begin
                r = ref_read(a);
                q.push_back('{due: cyc + RDL, d: r[63:0], err: r[64]});
            end
            m_gwv = 0; m_ewv = '0; clr = '0;
            if ((racc || wacc) && !mapped && m_bad < 65535) m_bad++;
            if (wacc && mapped) begin
                m_widx = idx; m_wdata = wdata;
                if (w == 0) m_gwv = 1; else m_ewv[w-1] = 1;
                if (w != 0 && idx == NC - 1) clr[w-1] = 1;
            end
            for (int e = 0; e < NE; e++) begin
                if (clr[e]) m_cyc[e] = 0;
                else if (active[e] && m_en[e] && m_cyc[e] < CYC_MAX) m_cyc[e]++;
            end
            if (wacc && mapped && w == 0 && idx == NC - 2) m_en = wdata[NE-1:0];
            m_init = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("readdatavalid", 64'(rvalid), 64'd1);
            chk("readdata", rdata, q[0].d);
            chk("response", 64'(resp), q[0].err ? 64'd3 : 64'd0);
            q.delete(0);
        end else begin
            chk("readdatavalid_idle", 64'(rvalid), 64'd0);
        end
        chk("glob_wr_valid", 64'(gwv), 64'(m_gwv));
        chk("eng_wr_valid", 64'(ewv), 64'(m_ewv));
        chk("eng_enable", 64'(en), 64'(m_en));
        if (m_gwv || m_ewv != 0) begin
            chk("wr_idx", 64'(wr_idx), 64'(m_widx));
            chk("wr_data", wr_data, m_wdata);
        end
    endtask

    task automatic idle(input int n);
        rd = 0; wr = 0;
        repeat (n) cycle();
    endtask

    task automatic do_rd(input int a);
        rd = 1; wr = 0; addr = AW'(a);
        cycle();
        rd = 0;
    endtask

    task automatic do_wr(input int a, input logic [63:0] d);
        rd = 0; wr = 1; addr = AW'(a); wdata = d;
        cycle();
        wr = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NC * 2; i++) glob[32*i +: 32] = $urandom();
        for (int i = 0; i < NE * NC * 2; i++) eng[32*i +: 32] = $urandom();
    endtask

    initial begin
        reset_n = 0; rd = 0; wr = 0; addr = '0; wdata = '0;
        glob = '0; eng = '0; active = '0;
        repeat (3) cycle();
        chk("reset_readdata", rdata, 64'd0);
        chk("reset_response", 64'(resp), 64'd0);
        chk("reset_wr_idx", 64'(wr_idx), 64'd0);
        chk("reset_wr_data", wr_data, 64'd0);
        reset_n = 1;
        idle(2);

        glob[63:0] = 64'hF8C7_E210_7050_4315;
        do_rd(0);
        idle(RDL + 1);

        do_wr(6, 64'h5);
        chk("enable_after_write", 64'(en), 64'h5);
        chk("enable_pulse_idx", 64'(wr_idx), 64'd6);
        idle(2);

        active = 4'hF;
        repeat (100) cycle();
        active = 4'h0;
        do_rd(15);
        do_rd(23);
        idle(RDL + 1);
        do_wr(15, {$urandom(), $urandom()});
        do_rd(15);
        idle(RDL + 1);

        do_rd(40);
        do_wr(56, 64'hDEAD_BEEF);
        do_rd(7);
        idle(RDL + 1);

        rand_data();
        for (int i = 0; i < 8; i++) begin
            rd = 1; wr = 0; addr = AW'(NC * (1 + i % NE) + i / NE);
            cycle();
        end
        idle(RDL + 1);

        active = 4'hF;
        do_wr(6, 64'hF);
        idle(5);
        do_rd(0);
        do_rd(8);
        reset_n = 0;
        idle(2);
        reset_n = 1;
        active = 4'h0;
        idle(RDL + 2);
        chk("enable_after_reset", 64'(en), 64'd0);
        do_rd(15);
        do_rd(6);
        idle(RDL + 1);

        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 7) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 47));
            wdata = {$urandom(), $urandom()};
            if ($urandom_range(0, 15) == 0) active = NE'($urandom());
            if ($urandom_range(0, 49) == 0) rand_data();
            cycle();
        end
        idle(RDL + 2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
